// File: rtl/lpc_arb_pkg.sv
// Shared types for the LPC/BMC register-file arbiter: FSM states, access record
// and the default BMC write-protect window.
`timescale 1ns/1ps
package lpc_arb_pkg;

    localparam int ACC_AW = 8;
    localparam int ACC_DW = 8;

    localparam logic [ACC_AW-1:0] PROT_LO_DEF = 8'hF0;
    localparam logic [ACC_AW-1:0] PROT_HI_DEF = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LPC_A,
        LPC_D,
        LPC_R,
        BMC_A,
        BMC_D,
        BMC_R
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ACC_AW-1:0] addr;
        logic [ACC_DW-1:0] data;
    } acc_t;

    // Compared one bit wider so a window edge at the address-space limit is not a constant compare.
    function automatic logic in_window(input logic [ACC_AW-1:0] a,
                                       input logic [ACC_AW-1:0] lo,
                                       input logic [ACC_AW-1:0] hi);
        return ({1'b0, a} >= {1'b0, lo}) && ({1'b0, a} <= {1'b0, hi});
    endfunction

endpackage

// File: rtl/lpc_req_buffer.sv
// One-entry capture of LPC strobes so none is lost while the register file is busy;
// a strobe that finds the entry occupied and not draining sets a sticky overrun flag.
`timescale 1ns/1ps
module lpc_req_buffer
    import lpc_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [ACC_AW-1:0] addr,
    input  logic [ACC_DW-1:0] data,
    input  logic              pop,
    output logic              pending,
    output acc_t              head,
    output logic              ovr
);

    logic strobe;
    logic full;
    acc_t entry;
    acc_t incoming;

    assign strobe   = wr | rd;
    assign incoming = '{we: wr, addr: addr, data: data};
    assign pending  = full | strobe;
    // Oldest access first; with the entry empty a strobe is handed straight to the FSM.
    assign head     = full ? entry : incoming;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            entry <= '0;
            ovr   <= 1'b0;
        end else if (full) begin
            if (strobe) begin
                if (pop) entry <= incoming;
                else     ovr   <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end
        end else if (strobe && !pop) begin
            entry <= incoming;
            full  <= 1'b1;
        end
    end

endmodule

// File: rtl/lpc_reg_arbiter.sv
// Serialises LPC and BMC accesses to the CPLD register file; LPC has strict
// priority and BMC writes into the protected window are suppressed and flagged.
`timescale 1ns/1ps
module lpc_reg_arbiter
    import lpc_arb_pkg::*;
#(
    parameter int              AW      = ACC_AW,
    parameter int              DW      = ACC_DW,
    parameter logic [AW-1:0]   PROT_LO = PROT_LO_DEF,
    parameter logic [AW-1:0]   PROT_HI = PROT_HI_DEF
) (
    input  logic          LpcClock,
    input  logic          PciReset,
    input  logic          LpcWr,
    input  logic          LpcRd,
    input  logic [AW-1:0] LpcAddr,
    input  logic [DW-1:0] LpcDataWr,
    output logic [DW-1:0] LpcDataRd,
    output logic          LpcRdValid,
    output logic          LpcOvr,
    input  logic          BmcReq,
    input  logic          BmcWe,
    input  logic [AW-1:0] BmcAddr,
    input  logic [DW-1:0] BmcDataWr,
    output logic          BmcGnt,
    output logic          BmcDone,
    output logic          BmcErr,
    output logic [DW-1:0] BmcDataRd,
    output logic [AW-1:0] RegAddr,
    output logic          RegWr,
    output logic [DW-1:0] RegDataWr,
    input  logic [DW-1:0] RegDataRd,
    output logic          Busy
);

    arb_state_t state;
    logic       pop;
    logic       pending;
    acc_t       head;
    acc_t       bmc_acc;
    logic       bmc_blk;
    logic       cur_we;
    logic       cur_blk;

    lpc_req_buffer u_buf (
        .clk     (LpcClock),
        .rst_n   (PciReset),
        .wr      (LpcWr),
        .rd      (LpcRd),
        .addr    (LpcAddr),
        .data    (LpcDataWr),
        .pop     (pop),
        .pending (pending),
        .head    (head),
        .ovr     (LpcOvr)
    );

    assign bmc_acc = '{we: BmcWe, addr: BmcAddr, data: BmcDataWr};
    assign bmc_blk = BmcWe && in_window(BmcAddr, PROT_LO, PROT_HI);
    // The buffer drains exactly on the edge that enters LPC_A.
    assign pop     = pending && (state == IDLE || state == LPC_R || state == BMC_R);

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state      <= IDLE;
            cur_we     <= 1'b0;
            cur_blk    <= 1'b0;
            RegAddr    <= '0;
            RegWr      <= 1'b0;
            RegDataWr  <= '0;
            LpcDataRd  <= '0;
            LpcRdValid <= 1'b0;
            BmcGnt     <= 1'b0;
            BmcDone    <= 1'b0;
            BmcErr     <= 1'b0;
            BmcDataRd  <= '0;
            Busy       <= 1'b0;
        end else begin
            RegWr      <= 1'b0;
            LpcRdValid <= 1'b0;
            BmcGnt     <= 1'b0;
            BmcDone    <= 1'b0;
            BmcErr     <= 1'b0;
            case (state)
                IDLE, LPC_R, BMC_R: begin
                    if (pop) begin
                        state     <= LPC_A;
                        cur_we    <= head.we;
                        RegAddr   <= head.addr;
                        RegWr     <= head.we;
                        RegDataWr <= head.data;
                        Busy      <= 1'b1;
                    end else if (state == IDLE && BmcReq) begin
                        // BmcReq is only honoured from IDLE so a requester still holding it in BMC_R is not re-granted.
                        state     <= BMC_A;
                        cur_we    <= bmc_acc.we;
                        cur_blk   <= bmc_blk;
                        RegAddr   <= bmc_acc.addr;
                        RegWr     <= bmc_acc.we && !bmc_blk;
                        RegDataWr <= bmc_acc.data;
                        BmcGnt    <= 1'b1;
                        Busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                LPC_A: state <= LPC_D;
                LPC_D: begin
                    state <= LPC_R;
                    if (!cur_we) begin
                        LpcRdValid <= 1'b1;
                        LpcDataRd  <= RegDataRd;
                    end
                end
                BMC_A: state <= BMC_D;
                BMC_D: begin
                    state   <= BMC_R;
                    BmcDone <= 1'b1;
                    BmcErr  <= cur_blk;
                    if (!cur_we) BmcDataRd <= RegDataRd;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_reg_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions and register writes,
// a negedge monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_lpc_reg_arbiter;

    logic       LpcClock = 1'b0;
    logic       PciReset = 1'b0;
    logic       LpcWr = 1'b0, LpcRd = 1'b0;
    logic [7:0] LpcAddr = '0, LpcDataWr = '0;
    logic [7:0] LpcDataRd;
    logic       LpcRdValid, LpcOvr;
    logic       BmcReq = 1'b0, BmcWe = 1'b0;
    logic [7:0] BmcAddr = '0, BmcDataWr = '0;
    logic       BmcGnt, BmcDone, BmcErr;
    logic [7:0] BmcDataRd;
    logic [7:0] RegAddr, RegDataWr;
    logic       RegWr;
    logic [7:0] RegDataRd = '0;
    logic       Busy;

    lpc_reg_arbiter dut (
        .LpcClock(LpcClock), .PciReset(PciReset),
        .LpcWr(LpcWr), .LpcRd(LpcRd), .LpcAddr(LpcAddr), .LpcDataWr(LpcDataWr),
        .LpcDataRd(LpcDataRd), .LpcRdValid(LpcRdValid), .LpcOvr(LpcOvr),
        .BmcReq(BmcReq), .BmcWe(BmcWe), .BmcAddr(BmcAddr), .BmcDataWr(BmcDataWr),
        .BmcGnt(BmcGnt), .BmcDone(BmcDone), .BmcErr(BmcErr), .BmcDataRd(BmcDataRd),
        .RegAddr(RegAddr), .RegWr(RegWr), .RegDataWr(RegDataWr), .RegDataRd(RegDataRd),
        .Busy(Busy)
    );

    always #15 LpcClock = ~LpcClock;

    int cyc = 0;
    always @(posedge LpcClock) cyc <= cyc + 1;

    // Power-up contents of the register file, distinct per address.
    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h7E;
    endfunction

    // Register file + registered readback mux seen by the arbiter.
    logic [7:0] env_mem [256];
    bit         env_wr  [256];
    always @(posedge LpcClock) begin
        if (RegWr) begin
            env_mem[RegAddr] <= RegDataWr;
            env_wr[RegAddr]  <= 1'b1;
        end
        RegDataRd <= env_wr[RegAddr] ? env_mem[RegAddr] : init_val(RegAddr);
    end

    typedef struct { int cyc; logic [7:0] data; } lpc_exp_t;
    typedef struct { int cyc; logic err; logic rd; logic [7:0] data; } bmc_exp_t;
    typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } wr_exp_t;

    lpc_exp_t lq[$];
    bmc_exp_t bq[$];
    wr_exp_t  wq[$];
    int       gq[$];
    logic [7:0] ref_mem [256];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge LpcClock) begin : monitor
        lpc_exp_t le;
        bmc_exp_t be;
        wr_exp_t  we;
        int       gc;
        if (PciReset) begin
            if (LpcRdValid) begin
                if (lq.size() == 0) chk("lpc_rdvalid_unexpected", 1, 0);
                else begin
                    le = lq.pop_front();
                    chk("lpc_rd_data", LpcDataRd, le.data);
                    chk("lpc_rd_cycle", cyc, le.cyc);
                end
            end
            if (BmcGnt) begin
                if (gq.size() == 0) chk("bmc_gnt_unexpected", 1, 0);
                else begin
                    gc = gq.pop_front();
                    chk("bmc_gnt_cycle", cyc, gc);
                end
            end
            if (BmcDone) begin
                if (bq.size() == 0) chk("bmc_done_unexpected", 1, 0);
                else begin
                    be = bq.pop_front();
                    chk("bmc_done_cycle", cyc, be.cyc);
                    chk("bmc_err", BmcErr, be.err);
                    if (be.rd) chk("bmc_rd_data", BmcDataRd, be.data);
                end
            end
            if (RegWr) begin
                if (wq.size() == 0) chk("regwr_unexpected", {RegAddr, RegDataWr}, 0);
                else begin
                    we = wq.pop_front();
                    chk("regwr_addr", RegAddr, we.addr);
                    chk("regwr_data", RegDataWr, we.data);
                    chk("regwr_cycle", cyc, we.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge LpcClock);
        #1;
    endtask

    task automatic check_zero(input string name);
        chk(name, {RegAddr, RegWr, RegDataWr, LpcDataRd, LpcRdValid, LpcOvr,
                   BmcGnt, BmcDone, BmcErr, BmcDataRd, Busy}, 0);
    endtask

    // Drives a one-cycle LPC strobe starting in the current cycle.
    task automatic lpc_drive(input logic w, input logic [7:0] a, input logic [7:0] d);
        LpcWr = w; LpcRd = ~w; LpcAddr = a; LpcDataWr = d;
        tick(1);
        LpcWr = 1'b0; LpcRd = 1'b0;
    endtask

    // extra = cycles the access waits behind other traffic before reaching LPC_A.
    task automatic lpc_issue(input logic w, input logic [7:0] a, input logic [7:0] d, input int extra);
        if (w) begin
            wq.push_back('{cyc: cyc + 1 + extra, addr: a, data: d});
            ref_mem[a] = d;
        end else begin
            lq.push_back('{cyc: cyc + 3 + extra, data: ref_mem[a]});
        end
        lpc_drive(w, a, d);
    endtask

    task automatic bmc_op(input logic w, input logic [7:0] a, input logic [7:0] d, input int extra);
        logic prot;
        bit   got;
        int   n;
        prot = w && (a >= 8'hF0);
        gq.push_back(cyc + 1 + extra);
        bq.push_back('{cyc: cyc + 3 + extra, err: prot, rd: ~w, data: ref_mem[a]});
        if (w && !prot) begin
            wq.push_back('{cyc: cyc + 1 + extra, addr: a, data: d});
            ref_mem[a] = d;
        end
        BmcReq = 1'b1; BmcWe = w; BmcAddr = a; BmcDataWr = d;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            tick(1);
            got = BmcDone;
            n++;
        end
        if (!got) chk("bmc_timeout", 0, 1);
        BmcReq = 1'b0;
    endtask

    initial begin
        #(30 * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

        // Reset state
        tick(3);
        check_zero("reset_outputs");
        PciReset = 1'b1;
        tick(2);

        // LPC write: RegWr with addr/data one cycle after the strobe, no read pulse
        lpc_issue(1'b1, 8'h10, 8'hA5, 0);
        chk("busy_after_lpc_strobe", Busy, 1);
        tick(3);

        // LPC read: mux data 0x5C back three cycles after the strobe
        lpc_issue(1'b0, 8'h22, 8'h00, 0);
        tick(3);

        // Contention: LPC first, BMC granted only after LPC_R -> IDLE
        fork
            lpc_issue(1'b0, 8'h31, 8'h00, 0);
            bmc_op(1'b0, 8'h30, 8'h00, 4);
        join
        tick(1);

        // Protection window edges
        bmc_op(1'b1, 8'hF4, 8'h11, 0); tick(1);
        lpc_issue(1'b0, 8'hF4, 8'h00, 0); tick(3);
        bmc_op(1'b1, 8'hEF, 8'h22, 0); tick(1);
        bmc_op(1'b1, 8'hF0, 8'h33, 0); tick(1);
        bmc_op(1'b1, 8'hFF, 8'h44, 0); tick(1);
        bmc_op(1'b0, 8'hEF, 8'h00, 0); tick(1);
        lpc_issue(1'b1, 8'hF0, 8'h66, 0); tick(3);
        bmc_op(1'b0, 8'hF0, 8'h00, 0); tick(1);

        // Overrun: read buffered during BMC_A, a second strobe next cycle is dropped
        chk("ovr_clear_before", LpcOvr, 0);
        fork
            bmc_op(1'b0, 8'h40, 8'h00, 0);
            begin
                tick(1);
                lpc_issue(1'b0, 8'h41, 8'h00, 2);
                lpc_drive(1'b1, 8'h42, 8'h77);
            end
        join
        chk("ovr_set", LpcOvr, 1);
        tick(4);
        lpc_issue(1'b0, 8'h42, 8'h00, 0); tick(3);

        // Randomised sequential traffic
        for (int i = 0; i < 60; i++) begin
            logic       w;
            logic [7:0] a, d;
            int         gap;
            w   = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 2);
            case ($urandom_range(0, 7))
                0:       a = 8'hEF;
                1:       a = 8'hF0;
                2:       a = 8'hFF;
                default: a = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                lpc_issue(w, a, d, 0);
                tick(3 + gap);
            end else begin
                bmc_op(w, a, d, 0);
                tick(1 + gap);
            end
        end

        // Reset during BMC_D: outputs clear at once, no completion pulse
        gq.push_back(cyc + 1);
        BmcReq = 1'b1; BmcWe = 1'b0; BmcAddr = 8'h50; BmcDataWr = 8'h00;
        tick(2);
        PciReset = 1'b0;
        #1;
        check_zero("reset_mid_access");
        BmcReq = 1'b0;
        tick(2);
        check_zero("reset_held");
        PciReset = 1'b1;
        tick(2);
        bmc_op(1'b0, 8'h50, 8'h00, 0);
        tick(1);
        bmc_op(1'b1, 8'h51, 8'h9C, 0);
        tick(1);
        lpc_issue(1'b0, 8'h51, 8'h00, 0);
        tick(5);

        chk("lpc_queue_drained", lq.size(), 0);
        chk("bmc_queue_drained", bq.size(), 0);
        chk("gnt_queue_drained", gq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
